cnn_stream_sequencer: RTL
=========================

// Module: cnn_stream_sequencer
// PURPOSE
//  Sequences one inference run on CNN_Accelerator_Top: accepts a host byte stream, forwards it
//  as weight bytes and then line bytes, pulses start, and buffers results in a small FIFO.
//  Sits between the user_project_wrapper LA/host byte stream and the accelerator serial ports.
//  Adds result/done sticky status and a watchdog timeout.
// PARAMETERS
//  NUM_W      64    weight bytes per run (>=1)
//  LINE_LEN   16    line bytes per run (>=1)
//  RES_DEPTH  8     result FIFO depth, power of 2 (>=2)
//  TIMEOUT    4096  max idle cycles in WAIT with no acc_result_valid/acc_done (>=2)
// PORTS
//  clk              in   1  clock (wb_clk_i domain)
//  reset            in   1  synchronous, active-high reset
//  cmd_go           in   1  1-cycle request to begin a run; honoured only in IDLE
//  cmd_skip_w       in   1  sampled with cmd_go: 1 = reuse loaded weights, skip LOAD_W
//  in_data          in   8  host byte
//  in_valid         in   1  host byte valid
//  in_ready         out  1  sequencer accepts in_data this cycle (in_valid & in_ready)
//  acc_start        out  1  start pulse to accelerator
//  acc_weight_data  out  8  weight byte to accelerator
//  acc_weight_valid out  1  weight byte strobe
//  acc_line_data    out  8  line byte to accelerator
//  acc_line_valid   out  1  line byte strobe
//  acc_result       in   8  accelerator result byte
//  acc_result_valid in   1  result byte strobe
//  acc_done         in   1  accelerator run complete
//  res_data         out  8  FIFO head (valid only when res_valid)
//  res_valid        out  1  FIFO non-empty
//  res_ready        in   1  pop; pop occurs on res_valid & res_ready
//  busy             out  1  state != IDLE
//  run_done         out  1  1-cycle pulse when a run ends (normally or by timeout)
//  err_timeout      out  1  sticky: WAIT watchdog expired; cleared by next accepted cmd_go
//  err_overflow     out  1  sticky: result arrived with FIFO full; cleared by next accepted cmd_go
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; FIFO emptied; byte/timeout counters 0.
//  States:
//  - IDLE   -> LOAD_W on cmd_go & !cmd_skip_w; -> LOAD_L on cmd_go & cmd_skip_w.
//  - LOAD_W -> LOAD_L after NUM_W accepted bytes.
//  - LOAD_L -> FIRE after LINE_LEN accepted bytes.
//  - FIRE   -> WAIT after exactly 1 cycle; acc_start=1 in FIRE only.
//  - WAIT   -> IDLE on acc_done, or when the timeout counter reaches TIMEOUT.
//  in_ready = 1 only in LOAD_W/LOAD_L; no byte is ever accepted in other states.
//  Forwarding: each accepted byte is registered onto acc_weight_* (LOAD_W) or acc_line_* (LOAD_L)
//   1 cycle later. The valid is a 1-cycle strobe. Data holds its last value otherwise.
//  The byte counter counts accepted bytes only; in_valid gaps stall without error.
//  Last byte: the state advances on the cycle its handshake occurs.
//  cmd_skip_w with no weights loaded since reset still skips LOAD_W; this is the host's responsibility.
//  Run start: cmd_go in any state other than IDLE is ignored (no flag set).
//  WAIT:
//  - Every acc_result_valid pushes acc_result into the FIFO and clears the timeout counter.
//  - Otherwise the counter increments each cycle.
//  - At TIMEOUT: err_timeout<=1, run_done pulse, -> IDLE.
//  - acc_result_valid & acc_done in the same cycle: the result is pushed first, then -> IDLE.
//  - run_done pulses in the cycle after the WAIT exit edge.
//  - acc_result_valid outside WAIT is also pushed; late results are not lost.
//  FIFO:
//  - Push when full and no pop in the same cycle: byte dropped, err_overflow<=1.
//  - Push and pop in the same cycle when full: both occur; no overflow.
//  - When empty, res_valid=0, so a push and res_ready in the same cycle stores the byte.
//  - Read latency: res_data/res_valid reflect a push on the next cycle (registered).
//  - The FIFO persists across runs; it is cleared only by reset.
//  Reset mid-run: immediate return to IDLE; acc_* outputs drop to 0 the next cycle.
// TESTING
//  T1 NUM_W=4,LINE_LEN=2: cmd_go, 6 bytes 0x01..0x06 back-to-back -> weight strobes 01..04,
//     then line strobes 05,06, each 1 cycle after acceptance; acc_start 1 cycle; busy=1.
//  T2 cmd_skip_w=1 with cmd_go -> no acc_weight_valid; the first 2 bytes go to acc_line_*.
//  T3 In WAIT, drive results 0xA0,0xA1 then acc_done in the same cycle as 0xA1 -> FIFO holds A0,A1;
//     run_done pulses once; state IDLE.
//  T4 TIMEOUT=8, no acc response -> err_timeout=1 and run_done 8 cycles after WAIT entry;
//     next cmd_go clears err_timeout.
//  T5 RES_DEPTH=2, res_ready=0, push 3 results -> err_overflow=1, FIFO holds the first 2;
//     push+pop while full -> no overflow.
//  T6 Assert reset during LOAD_L with bytes half sent -> next cycle busy=0, in_ready=0, FIFO empty;
//     a new run completes normally.

Source files
------------

// File: rtl/cnn_stream_sequencer_if.sv
// rtl/cnn_stream_sequencer_if.sv - host byte stream, accelerator serial ports and result stream
interface cnn_stream_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       acc_start;
  logic [7:0] acc_weight_data;
  logic       acc_weight_valid;
  logic [7:0] acc_line_data;
  logic       acc_line_valid;
  logic [7:0] acc_result;
  logic       acc_result_valid;
  logic       acc_done;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;

  modport master (
    input  in_data, in_valid, acc_result, acc_result_valid, acc_done, res_ready,
    output in_ready, acc_start, acc_weight_data, acc_weight_valid,
    output acc_line_data, acc_line_valid, res_data, res_valid
  );

  modport slave (
    output in_data, in_valid, acc_result, acc_result_valid, acc_done, res_ready,
    input  in_ready, acc_start, acc_weight_data, acc_weight_valid,
    input  acc_line_data, acc_line_valid, res_data, res_valid
  );
endinterface

// File: rtl/cnn_stream_sequencer.sv
// rtl/cnn_stream_sequencer.sv - sequences weight/line load, start pulse and result buffering for one run
module cnn_stream_sequencer #(
  parameter int NUM_W     = 64,
  parameter int LINE_LEN  = 16,
  parameter int RES_DEPTH = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_go,
  input  logic                          cmd_skip_w,
  cnn_stream_sequencer_if.master        sq,
  output logic                          busy,
  output logic                          run_done,
  output logic                          err_timeout,
  output logic                          err_overflow
);
  localparam int MAXB = (NUM_W > LINE_LEN) ? NUM_W : LINE_LEN;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int AW   = $clog2(RES_DEPTH);
  localparam logic [CW-1:0] W_LAST   = CW'(NUM_W - 1);
  localparam logic [CW-1:0] L_LAST   = CW'(LINE_LEN - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(RES_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_L, FIRE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   byte_cnt;
  logic [TW-1:0]   idle_cnt;
  logic            accept, go, run_end, wd_fire;
  logic [7:0]      mem [RES_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fill;
  logic            full, pop, push, overflow;

  assign go     = (state == IDLE) & cmd_go;
  assign accept = sq.in_valid & sq.in_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    sq.in_ready  = 1'b0;
    sq.acc_start = 1'b0;
    run_end      = 1'b0;
    wd_fire      = 1'b0;
    case (state)
      IDLE:   if (cmd_go) state_nxt = cmd_skip_w ? LOAD_L : LOAD_W;
      LOAD_W: begin
        sq.in_ready = 1'b1;
        if (sq.in_valid && byte_cnt == W_LAST) state_nxt = LOAD_L;
      end
      LOAD_L: begin
        sq.in_ready = 1'b1;
        if (sq.in_valid && byte_cnt == L_LAST) state_nxt = FIRE;
      end
      FIRE: begin
        sq.acc_start = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        // A result in the final watchdog cycle rearms the counter instead of timing out
        wd_fire = !sq.acc_done && !sq.acc_result_valid && (idle_cnt == T_LAST);
        if (sq.acc_done || wd_fire) begin
          run_end   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt            <= '0;
      idle_cnt            <= '0;
      sq.acc_weight_data  <= '0;
      sq.acc_weight_valid <= 1'b0;
      sq.acc_line_data    <= '0;
      sq.acc_line_valid   <= 1'b0;
      run_done            <= 1'b0;
      err_timeout         <= 1'b0;
      err_overflow        <= 1'b0;
    end else begin
      run_done <= run_end;
      if (accept) byte_cnt <= (state_nxt != state) ? '0 : byte_cnt + 1'b1;
      idle_cnt <= (state == WAIT && !sq.acc_result_valid) ? idle_cnt + 1'b1 : '0;
      sq.acc_weight_valid <= accept && (state == LOAD_W);
      sq.acc_line_valid   <= accept && (state == LOAD_L);
      if (accept && state == LOAD_W) sq.acc_weight_data <= sq.in_data;
      if (accept && state == LOAD_L) sq.acc_line_data   <= sq.in_data;
      if (go) begin
        err_timeout  <= 1'b0;
        err_overflow <= 1'b0;
      end
      if (wd_fire)  err_timeout  <= 1'b1;
      if (overflow) err_overflow <= 1'b1;
    end
  end

  // Result FIFO accepts late results in any state and survives across runs
  assign full     = (fill == FULL_CNT);
  assign pop      = sq.res_valid & sq.res_ready;
  assign push     = sq.acc_result_valid & (!full | pop);
  assign overflow = sq.acc_result_valid & full & !pop;

  assign sq.res_valid = (fill != '0);
  assign sq.res_data  = sq.res_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sq.acc_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end
endmodule
